// File: rtl/ncpu32k_bus_arbiter_if.sv
// ncpu32k_bus_arbiter_if: request/grant bundle between requesters, the shared
// resource and the round-robin arbiter.
//   req    : per-requester request lines, active high (bit i = requester i)
//   done   : pulse from the shared resource on the owner's last cycle
//   gnt    : registered one-hot (or all-zero) grant vector
//   gnt_id : registered binary index of the granted requester (0 when idle)
//   busy   : high while any grant is held
// Modports: slave = arbiter side, master = requester/resource side.
interface ncpu32k_bus_arbiter_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
);
    logic [NREQ-1:0] req;
    logic            done;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_id;
    logic            busy;

    modport slave (
        input  req,
        input  done,
        output gnt,
        output gnt_id,
        output busy
    );

    modport master (
        output req,
        output done,
        input  gnt,
        input  gnt_id,
        input  busy
    );
endinterface

// File: rtl/ncpu32k_bus_arbiter.sv
// ncpu32k_bus_arbiter: round-robin arbiter granting one shared resource to one
// of NREQ requesters. A grant is held until the resource pulses done; the next
// owner is then chosen in the same cycle with the previous owner at lowest
// priority, so ownership can pass back-to-back without an idle cycle.
// Ports:
//   clk   : clock, all state on its rising edge
//   rst_n : synchronous active-low reset
//   bus   : slave side of ncpu32k_bus_arbiter_if (req/done in, gnt/gnt_id/busy out)
module ncpu32k_bus_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ncpu32k_bus_arbiter_if.slave   bus
);

    // One extra bit so index sums never overflow before the modulo fold.
    localparam int unsigned SW = IDW + 1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_OWNED = 1'b1
    } state_t;

    state_t          state_q, state_nxt;
    logic [IDW-1:0]  ptr_q, ptr_nxt;
    logic [NREQ-1:0] gnt_q, gnt_nxt;
    logic [IDW-1:0]  gnt_id_q, gnt_id_nxt;
    logic            busy_q, busy_nxt;

    logic [IDW-1:0]  id_inc;
    logic [IDW-1:0]  arb_ptr;
    logic [NREQ-1:0] rot;
    logic [IDW-1:0]  win_ofs;
    logic [SW-1:0]   win_sum;
    logic [IDW-1:0]  win_idx;
    logic [NREQ-1:0] win_oh;
    logic            req_any;

    // (gnt_id + 1) mod NREQ: pointer value loaded when the owner finishes.
    always_comb begin
        logic [SW-1:0] sum;
        sum = SW'(gnt_id_q) + SW'(1);
        if (sum >= SW'(NREQ)) begin
            sum = '0;
        end
        id_inc = IDW'(sum);
    end

    // On done the freshly updated pointer takes effect for this cycle's pick.
    always_comb begin
        arb_ptr = ptr_q;
        if ((state_q == S_OWNED) && bus.done) begin
            arb_ptr = id_inc;
        end
    end

    // Rotate right by arb_ptr, take the lowest set bit, rotate the index back.
    always_comb begin
        rot     = NREQ'({bus.req, bus.req} >> arb_ptr);
        req_any = |bus.req;
        win_ofs = '0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            if (rot[i]) begin
                win_ofs = IDW'(i);
            end
        end
        win_sum = SW'(win_ofs) + SW'(arb_ptr);
        if (win_sum >= SW'(NREQ)) begin
            win_sum = win_sum - SW'(NREQ);
        end
        win_idx = IDW'(win_sum);
        win_oh  = NREQ'(1) << win_idx;
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt  = state_q;
        ptr_nxt    = ptr_q;
        gnt_nxt    = gnt_q;
        gnt_id_nxt = gnt_id_q;
        busy_nxt   = busy_q;

        case (state_q)
            S_IDLE: begin
                // done is meaningless without an owner and is ignored here.
                if (req_any) begin
                    state_nxt  = S_OWNED;
                    gnt_nxt    = win_oh;
                    gnt_id_nxt = win_idx;
                    busy_nxt   = 1'b1;
                end
            end
            S_OWNED: begin
                // Grant is held until done, even if the owner drops its request.
                if (bus.done) begin
                    ptr_nxt = id_inc;
                    if (req_any) begin
                        gnt_nxt    = win_oh;
                        gnt_id_nxt = win_idx;
                        busy_nxt   = 1'b1;
                    end else begin
                        state_nxt  = S_IDLE;
                        gnt_nxt    = '0;
                        gnt_id_nxt = '0;
                        busy_nxt   = 1'b0;
                    end
                end
            end
            default: begin
                state_nxt  = S_IDLE;
                gnt_nxt    = '0;
                gnt_id_nxt = '0;
                busy_nxt   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset dominates req and done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            ptr_q    <= ptr_nxt;
            gnt_q    <= gnt_nxt;
            gnt_id_q <= gnt_id_nxt;
            busy_q   <= busy_nxt;
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.gnt_id = gnt_id_q;
    assign bus.busy   = busy_q;

endmodule
